// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame sampler.
package uart_rx_pkg;

  localparam int unsigned PRESCALE_W = 6;
  localparam int unsigned EDGE_W     = 6;

  localparam logic [PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
  localparam logic [PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
  localparam logic [PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // 2-of-3 vote used for the per-bit decision.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // True for the oversampling ratios the receiver is built for.
  function automatic logic prescale_legal(input logic [PRESCALE_W-1:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_frame_sampler_if.sv
// Serial line, configuration and result signals of the frame sampler.
interface uart_rx_frame_sampler_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic                                 rx_in;
  logic [uart_rx_pkg::PRESCALE_W-1:0]   prescale;
  logic                                 par_en;
  logic                                 par_err;
  logic [DATA_WIDTH-1:0]                p_data;
  logic                                 sampled_bit;
  logic                                 par_chk_en;
  logic                                 data_valid;
  logic                                 strt_glitch;
  logic                                 stop_err;

  modport master (
    output rx_in, prescale, par_en, par_err,
    input  p_data, sampled_bit, par_chk_en, data_valid, strt_glitch, stop_err
  );

  modport slave (
    input  rx_in, prescale, par_en, par_err,
    output p_data, sampled_bit, par_chk_en, data_valid, strt_glitch, stop_err
  );

endinterface

// File: rtl/uart_rx_data_sampling.sv
// Three-point majority sampler around the middle of each bit period.
module uart_rx_data_sampling
  import uart_rx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [EDGE_W-1:0]     edge_cnt,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sampled_bit
);

  logic [EDGE_W-1:0] half_c;
  logic              s0_q;
  logic              s1_q;

  assign half_c = EDGE_W'(prescale >> 1);

  // Capture at P/2-1 and P/2, vote with the live line at P/2+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q        <= 1'b1;
      s1_q        <= 1'b1;
      sampled_bit <= 1'b1;
    end else begin
      if (edge_cnt == EDGE_W'(half_c - EDGE_W'(1))) s0_q <= rx_in;
      if (edge_cnt == half_c)                       s1_q <= rx_in;
      if (edge_cnt == EDGE_W'(half_c + EDGE_W'(1))) sampled_bit <= majority3(s0_q, s1_q, rx_in);
    end
  end

endmodule

// File: rtl/uart_rx_frame_sampler.sv
// UART receive frame FSM: start detect, data shift, parity hand-off, stop check.
module uart_rx_frame_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  uart_rx_frame_sampler_if.slave  bus
);

  localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);

  rx_state_e               state_q, state_d;
  logic [EDGE_W-1:0]       edge_q, edge_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [PRESCALE_W-1:0]   pre_q, pre_d;
  logic                    par_en_q, par_en_d;
  logic                    par_chk_q, par_chk_d;
  logic                    valid_q, valid_d;
  logic                    glitch_q, glitch_d;
  logic                    stop_err_q, stop_err_d;
  logic                    sampled_bit;
  logic                    bit_end;

  uart_rx_data_sampling u_sampling (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (bus.rx_in),
    .edge_cnt    (edge_q),
    .prescale    (pre_q),
    .sampled_bit (sampled_bit)
  );

  // Last oversampling edge of the current bit; an illegal ratio still wraps.
  assign bit_end = (edge_q == EDGE_W'(pre_q - PRESCALE_W'(1)));

  // State, counters, frame configuration and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      pre_q      <= PRESCALE_8;
      par_en_q   <= 1'b0;
      par_chk_q  <= 1'b0;
      valid_q    <= 1'b0;
      glitch_q   <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      pre_q      <= pre_d;
      par_en_q   <= par_en_d;
      par_chk_q  <= par_chk_d;
      valid_q    <= valid_d;
      glitch_q   <= glitch_d;
      stop_err_q <= stop_err_d;
    end
  end

  // Next-state, counter and strobe decisions; bit ends act on the voted bit.
  always_comb begin
    state_d    = state_q;
    edge_d     = edge_q;
    bit_d      = bit_q;
    data_d     = data_q;
    pre_d      = pre_q;
    par_en_d   = par_en_q;
    par_chk_d  = 1'b0;
    valid_d    = 1'b0;
    glitch_d   = 1'b0;
    stop_err_d = 1'b0;

    if (state_q != IDLE) begin
      edge_d = bit_end ? '0 : EDGE_W'(edge_q + EDGE_W'(1));
    end

    case (state_q)
      IDLE: begin
        if (!bus.rx_in) begin
          state_d  = START;
          edge_d   = EDGE_W'(1);
          pre_d    = bus.prescale;
          par_en_d = bus.par_en;
        end
      end
      START: begin
        if (bit_end) begin
          if (sampled_bit) begin
            glitch_d = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d  = DATA;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          data_d = {sampled_bit, data_q[DATA_WIDTH-1:1]};
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d   = BIT_W'(bit_q + BIT_W'(1));
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_chk_d = 1'b1;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          if (!sampled_bit) begin
            stop_err_d = 1'b1;
          end else if (!(par_en_q && bus.par_err)) begin
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        edge_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  assign bus.p_data      = data_q;
  assign bus.sampled_bit = sampled_bit;
  assign bus.par_chk_en  = par_chk_q;
  assign bus.data_valid  = valid_q;
  assign bus.strt_glitch = glitch_q;
  assign bus.stop_err    = stop_err_q;

endmodule

// File: tb/tb_uart_rx_frame_sampler.sv
// Frame-level bench: fixed vectors, hand sequences and random frames vs. a frame model.
module tb_uart_rx_frame_sampler;
  import uart_rx_pkg::*;

  typedef struct {
    logic [7:0] data;
    int         p;
    logic       pen;
    logic       par_bit;
    logic       stop_bit;
    logic       force_perr;
    int         glitch_len;
    logic       exp_valid;
    logic       exp_stop;
    logic       exp_pchk;
    logic       exp_glitch;
    logic [7:0] exp_pdata;
    int         exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_frame_sampler_if #(.DATA_WIDTH(8)) bif();

  uart_rx_frame_sampler #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed strobe history, plus the downstream parity checker.
  int         n_valid = 0;
  int         n_stop = 0;
  int         n_glitch = 0;
  int         n_pchk = 0;
  int         last_term_cyc = 0;
  logic       pchk_sbit = 1'b0;
  logic [7:0] pchk_data = 8'h00;
  int         valid_cyc_q[$];
  logic [7:0] valid_data_q[$];
  logic       force_perr = 1'b0;

  always @(negedge clk) begin
    if (bif.data_valid) begin
      n_valid++;
      last_term_cyc = cyc;
      valid_cyc_q.push_back(cyc);
      valid_data_q.push_back(bif.p_data);
    end
    if (bif.stop_err) begin
      n_stop++;
      last_term_cyc = cyc;
    end
    if (bif.strt_glitch) begin
      n_glitch++;
      last_term_cyc = cyc;
    end
    if (rst) begin
      bif.par_err = 1'b0;
    end else if (bif.par_chk_en) begin
      n_pchk++;
      pchk_sbit   = bif.sampled_bit;
      pchk_data   = bif.p_data;
      bif.par_err = force_perr | (^bif.p_data ^ bif.sampled_bit);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one frame (or a short false start); prescale/par_en are scrambled after the first cycle.
  task automatic send_frame(input vec_t v, output int start_cyc);
    logic [10:0] fr;
    int nb;
    int total;
    int idx;
    fr = '1;
    fr[0] = 1'b0;
    fr[8:1] = v.data;
    if (v.pen) begin
      fr[9]  = v.par_bit;
      fr[10] = v.stop_bit;
      nb = 11;
    end else begin
      fr[9] = v.stop_bit;
      nb = 10;
    end
    total = (v.glitch_len > 0) ? v.p : nb * v.p;
    start_cyc = 0;
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      idx = i / v.p;
      if (v.glitch_len > 0) bif.rx_in = (i >= v.glitch_len);
      else                  bif.rx_in = fr[idx];
      if (i == 0) begin
        start_cyc    = cyc;
        bif.prescale = 6'(v.p);
        bif.par_en   = v.pen;
      end else begin
        bif.prescale = 6'($urandom);
        bif.par_en   = 1'($urandom);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bif.rx_in = 1'b1;
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    int b_valid, b_stop, b_glitch, b_pchk, sc;
    b_valid  = n_valid;
    b_stop   = n_stop;
    b_glitch = n_glitch;
    b_pchk   = n_pchk;
    force_perr = v.force_perr;
    send_frame(v, sc);
    idle(3);
    check({tag, ".data_valid"},  n_valid - b_valid,   int'(v.exp_valid));
    check({tag, ".stop_err"},    n_stop - b_stop,     int'(v.exp_stop));
    check({tag, ".strt_glitch"}, n_glitch - b_glitch, int'(v.exp_glitch));
    check({tag, ".par_chk_en"},  n_pchk - b_pchk,     int'(v.exp_pchk));
    check({tag, ".p_data"},      int'(bif.p_data),    int'(v.exp_pdata));
    if (v.exp_pchk && (n_pchk != b_pchk)) begin
      check({tag, ".pchk_sbit"}, int'(pchk_sbit), int'(v.par_bit));
      check({tag, ".pchk_data"}, int'(pchk_data), int'(v.data));
    end
    if (v.exp_lat != 0) check({tag, ".latency"}, last_term_cyc - sc, v.exp_lat);
  endtask

  // Reference frame model: outcome follows from the framing rules alone.
  function automatic vec_t model(input logic [7:0] d, input int p, input logic pen,
                                 input logic par_bit, input logic stop_bit,
                                 input logic fperr, input int glen, input logic [7:0] prev);
    vec_t v;
    logic perr;
    int nb;
    v.data = d; v.p = p; v.pen = pen; v.par_bit = par_bit; v.stop_bit = stop_bit;
    v.force_perr = fperr; v.glitch_len = glen;
    nb = pen ? 11 : 10;
    if (glen > 0) begin
      v.exp_valid = 1'b0; v.exp_stop = 1'b0; v.exp_pchk = 1'b0; v.exp_glitch = 1'b1;
      v.exp_pdata = prev; v.exp_lat = p;
    end else begin
      perr = pen && (fperr || (par_bit != ^d));
      v.exp_valid  = stop_bit && !perr;
      v.exp_stop   = !stop_bit;
      v.exp_pchk   = pen;
      v.exp_glitch = 1'b0;
      v.exp_pdata  = d;
      v.exp_lat    = (v.exp_valid || v.exp_stop) ? nb * p : 0;
    end
    return v;
  endfunction

  vec_t       tbl[6];
  vec_t       v;
  logic [7:0] model_pdata;
  int         b_valid, b_stop, b_glitch, b_pchk, sc;

  initial begin
    //            data   p   pen  par  stop fperr glen  valid stop pchk glitch pdata  lat
    tbl[0] = '{8'hA5,  8, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5,  88};
    tbl[1] = '{8'h00, 16, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5,  16};
    tbl[2] = '{8'h3C, 32, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 320};
    tbl[3] = '{8'h5A,  8, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A,   0};
    tbl[4] = '{8'hFF, 16, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF,   0};
    tbl[5] = '{8'h00, 32, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 352};

    rst = 1'b1;
    bif.rx_in = 1'b1;
    bif.prescale = PRESCALE_16;
    bif.par_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.p_data",      int'(bif.p_data),      0);
    check("reset.sampled_bit", int'(bif.sampled_bit), 1);
    check("reset.data_valid",  int'(bif.data_valid),  0);
    check("reset.strt_glitch", int'(bif.strt_glitch), 0);
    check("reset.stop_err",    int'(bif.stop_err),    0);
    check("reset.par_chk_en",  int'(bif.par_chk_en),  0);
    rst = 1'b0;
    idle(4);

    for (int i = 0; i < 6; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset during data bit 3 at P=8.
    force_perr = 1'b0;
    b_valid = n_valid; b_stop = n_stop; b_glitch = n_glitch; b_pchk = n_pchk;
    for (int i = 0; i < 8 + 24 + 4; i++) begin
      @(negedge clk);
      bif.rx_in = (i >= 8);
      bif.prescale = PRESCALE_8;
      bif.par_en = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    bif.rx_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst.p_data",      int'(bif.p_data),      0);
    check("midrst.sampled_bit", int'(bif.sampled_bit), 1);
    check("midrst.data_valid",  int'(bif.data_valid),  0);
    check("midrst.stop_err",    int'(bif.stop_err),    0);
    idle(40);
    check("midrst.no_valid",  n_valid - b_valid,   0);
    check("midrst.no_stop",   n_stop - b_stop,     0);
    check("midrst.no_glitch", n_glitch - b_glitch, 0);
    check("midrst.no_pchk",   n_pchk - b_pchk,     0);
    apply(model(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00), "after_rst");

    // Two frames with no idle gap at P=16.
    b_valid = n_valid;
    send_frame(model(8'h01, 16, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00), sc);
    send_frame(model(8'hFF, 16, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00), sc);
    idle(3);
    check("b2b.valid_count", n_valid - b_valid, 2);
    if (valid_cyc_q.size() >= 2 && n_valid - b_valid >= 2) begin
      check("b2b.spacing", valid_cyc_q[valid_cyc_q.size()-1] - valid_cyc_q[valid_cyc_q.size()-2], 160);
      check("b2b.first",   int'(valid_data_q[valid_data_q.size()-2]), 8'h01);
      check("b2b.second",  int'(valid_data_q[valid_data_q.size()-1]), 8'hFF);
    end

    // Random frames, including false starts, bad parity and bad stop bits.
    model_pdata = 8'hFF;
    for (int i = 0; i < 40; i++) begin
      int         p;
      int         glen;
      logic [7:0] d;
      logic       pen;
      logic       pb;
      logic       sb;
      logic       fe;
      case ($urandom_range(0, 2))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      d    = 8'($urandom);
      pen  = 1'($urandom);
      pb   = (^d) ^ ($urandom_range(0, 4) == 0);
      sb   = ($urandom_range(0, 6) != 0);
      fe   = ($urandom_range(0, 4) == 0);
      glen = ($urandom_range(0, 7) == 0) ? $urandom_range(1, p / 2 - 1) : 0;
      v = model(d, p, pen, pb, sb, fe, glen, model_pdata);
      apply(v, $sformatf("rnd%0d", i));
      model_pdata = v.exp_pdata;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
